alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle combinational ALU.
- Keeps the eight existing operations (codes 0000-0111, identical semantics) and adds iterative unsigned MUL, DIVU and REMU.
- Inputs and outputs use a valid/ready handshake; results are registered.
- Sits in the EX stage of the next CPU revision; the pipeline stalls on ready_o low.

---
 rtl/alu_mc.sv | 183 ++++++++++++++++++
 tb/tb_alu_mc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith/shift ops,
// iterative shift-add MUL and restoring DIVU/REMU, all results registered.
module alu_mc #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic [3:0]       ALUCtrl_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   localparam int CNT_W = SHAMT_W + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CALC = 1'b1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;

   localparam logic [1:0] K_MUL = 2'd0;
   localparam logic [1:0] K_DIV = 2'd1;
   localparam logic [1:0] K_REM = 2'd2;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       kind_q, kind_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;

   logic [SHAMT_W-1:0] shamt_s;
   logic [WIDTH-1:0]   res1_s;
   logic               div_op_s;
   logic               multi_s;
   logic [WIDTH-1:0]   mul_acc_s;
   logic [WIDTH:0]     trial_s;
   logic [WIDTH:0]     diff_s;
   logic               qbit_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   quo_s;

   assign shamt_s  = data2_i[SHAMT_W-1:0];
   assign div_op_s = (ALUCtrl_i == OP_DIVU) || (ALUCtrl_i == OP_REMU);
   assign multi_s  = (ALUCtrl_i == OP_MUL) || (div_op_s && (data2_i != {WIDTH{1'b0}}));

   // Single-cycle result, including the divide-by-zero short-circuit
   always_comb begin
      res1_s = {WIDTH{1'b0}};
      case (ALUCtrl_i)
         OP_ADD:  res1_s = data1_i + data2_i;
         OP_SUB:  res1_s = data1_i - data2_i;
         OP_AND:  res1_s = data1_i & data2_i;
         OP_OR:   res1_s = data1_i | data2_i;
         OP_XOR:  res1_s = data1_i ^ data2_i;
         OP_SLL:  res1_s = data1_i << shamt_s;
         OP_SRA:  res1_s = WIDTH'($signed(data1_i) >>> shamt_s);
         OP_SRL:  res1_s = data1_i >> shamt_s;
         OP_DIVU: res1_s = {WIDTH{1'b1}};
         OP_REMU: res1_s = data1_i;
         default: res1_s = {WIDTH{1'b0}};
      endcase
   end

   // One iteration step: acc_q is the product (MUL) or partial remainder (DIV),
   // a_q shifts the dividend out while the quotient bits shift in behind it
   assign mul_acc_s = acc_q + (b_q[0] ? a_q : {WIDTH{1'b0}});
   assign trial_s   = {acc_q, a_q[WIDTH-1]};
   assign diff_s    = trial_s - {1'b0, b_q};
   assign qbit_s    = (trial_s >= {1'b0, b_q});
   assign rem_s     = qbit_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
   assign quo_s     = {a_q[WIDTH-2:0], qbit_s};

   // Next-state and result selection
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      valid_d = 1'b0;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (multi_s) begin
                  state_d = ST_CALC;
                  cnt_d   = CNT_W'(WIDTH);
                  a_d     = data1_i;
                  b_d     = data2_i;
                  acc_d   = {WIDTH{1'b0}};
                  if (ALUCtrl_i == OP_MUL) begin
                     kind_d = K_MUL;
                  end else if (ALUCtrl_i == OP_DIVU) begin
                     kind_d = K_DIV;
                  end else begin
                     kind_d = K_REM;
                  end
               end else begin
                  valid_d = 1'b1;
                  data_d  = res1_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (kind_q == K_MUL) begin
               acc_d = mul_acc_s;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else begin
               acc_d = rem_s;
               a_d   = quo_s;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               valid_d = 1'b1;
               case (kind_q)
                  K_MUL:   data_d = mul_acc_s;
                  K_DIV:   data_d = quo_s;
                  default: data_d = rem_s;
               endcase
            end else begin
               state_d = ST_CALC;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      zero_d = (data_d == {WIDTH{1'b0}});
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         kind_q  <= K_MUL;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
         data_q  <= {WIDTH{1'b0}};
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance checked every cycle against
// an arithmetic reference model, with hand-computed results pinned per request.
module tb_alu_mc;

   logic        clk;
   logic        rst;
   logic        vi[2];
   logic [3:0]  opi[2];
   logic [31:0] d1[2];
   logic [31:0] d2[2];
   logic        pin_en[2];
   logic [31:0] pin_val[2];

   logic        rdy0, vo0, zo0, rdy1, vo1, zo1;
   logic [31:0] dout0;
   logic [7:0]  dout1;

   int          checks = 0;
   int          failures = 0;

   int          busy[2] = '{0, 0};
   logic        expv[2] = '{1'b0, 1'b0};
   logic [31:0] last[2] = '{32'd0, 32'd0};
   logic [31:0] pend[2] = '{32'd0, 32'd0};
   logic        pend_pe[2] = '{1'b0, 1'b0};
   logic [31:0] pend_pv[2] = '{32'd0, 32'd0};
   logic        cur_pe[2] = '{1'b0, 1'b0};
   logic [31:0] cur_pv[2] = '{32'd0, 32'd0};

   alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut32 (
      .clk_i(clk), .rst_i(rst), .valid_i(vi[0]), .ready_o(rdy0),
      .data1_i(d1[0]), .data2_i(d2[0]), .ALUCtrl_i(opi[0]),
      .valid_o(vo0), .data_o(dout0), .zero_o(zo0));

   alu_mc #(.WIDTH(8), .SHAMT_W(3)) dut8 (
      .clk_i(clk), .rst_i(rst), .valid_i(vi[1]), .ready_o(rdy1),
      .data1_i(d1[1][7:0]), .data2_i(d2[1][7:0]), .ALUCtrl_i(opi[1]),
      .valid_o(vo1), .data_o(dout1), .zero_o(zo1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] ai,
                                          input logic [31:0] bi, input int w);
      logic [63:0] mask, a, b, sa, r;
      int sh;
      mask = (64'd1 << w) - 64'd1;
      a    = {32'd0, ai} & mask;
      b    = {32'd0, bi} & mask;
      sh   = int'(b & 64'(w - 1));
      sa   = a[w-1] ? (a | ~mask) : a;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << sh;
         4'd6:    r = 64'($signed(sa) >>> sh);
         4'd7:    r = a >> sh;
         4'd8:    r = a * b;
         4'd9:    r = (b == 64'd0) ? mask : a / b;
         4'd10:   r = (b == 64'd0) ? a : a % b;
         default: r = 64'd0;
      endcase
      return 32'(r & mask);
   endfunction

   function automatic bit is_multi(input logic [3:0] op, input logic [31:0] bi, input int w);
      logic [31:0] m;
      m = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
      return (op == 4'd8) || (((op == 4'd9) || (op == 4'd10)) && ((bi & m) != 32'd0));
   endfunction

   // Reference model: accept when idle, deliver after 1 or WIDTH edges
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int g = 0; g < 2; g++) begin
            busy[g] = 0; expv[g] = 1'b0; last[g] = 32'd0; cur_pe[g] = 1'b0;
         end
      end else begin
         for (int g = 0; g < 2; g++) begin
            int w;
            logic [31:0] r;
            w = (g == 0) ? 32 : 8;
            expv[g] = 1'b0;
            cur_pe[g] = 1'b0;
            if (busy[g] > 0) begin
               busy[g] = busy[g] - 1;
               if (busy[g] == 0) begin
                  expv[g] = 1'b1; last[g] = pend[g];
                  cur_pe[g] = pend_pe[g]; cur_pv[g] = pend_pv[g];
               end
            end else if (vi[g]) begin
               r = ref_op(opi[g], d1[g], d2[g], w);
               if (is_multi(opi[g], d2[g], w)) begin
                  busy[g] = w; pend[g] = r;
                  pend_pe[g] = pin_en[g]; pend_pv[g] = pin_val[g];
               end else begin
                  expv[g] = 1'b1; last[g] = r;
                  cur_pe[g] = pin_en[g]; cur_pv[g] = pin_val[g];
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, g, act, req, $time);
      end
   endtask

   // Every-cycle comparison, away from the rising edge
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         logic [31:0] d;
         logic r, v, z;
         d = (g == 0) ? dout0 : {24'd0, dout1};
         r = (g == 0) ? rdy0 : rdy1;
         v = (g == 0) ? vo0 : vo1;
         z = (g == 0) ? zo0 : zo1;
         chk("ready", g, {31'd0, r}, {31'd0, (busy[g] == 0)});
         chk("valid", g, {31'd0, v}, {31'd0, expv[g]});
         chk("data", g, d, last[g]);
         chk("zero", g, {31'd0, z}, {31'd0, (last[g] == 32'd0)});
         if (expv[g] && cur_pe[g]) chk("pinned", g, d, cur_pv[g]);
      end
   end

   task automatic issue(input int g, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pv);
      @(negedge clk);
      vi[g] = 1'b1; opi[g] = op; d1[g] = a; d2[g] = b;
      pin_en[g] = 1'b1; pin_val[g] = pv;
      @(posedge clk);
      #1;
      vi[g] = 1'b0; pin_en[g] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         vi[g] = 1'b0; opi[g] = 4'd0; d1[g] = 32'd0; d2[g] = 32'd0;
         pin_en[g] = 1'b0; pin_val[g] = 32'd0;
      end
      rst = 1'b1;
      #3 rst = 1'b0;
      idle(3);
      rst = 1'b1;

      issue(0, 4'b0000, 32'h7fff_ffff, 32'h0000_0001, 32'h8000_0000);
      idle(2);

      issue(0, 4'b0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
      issue(0, 4'b0101, 32'h0000_0001, 32'h0001_0001, 32'h0000_0002);
      issue(0, 4'b0110, 32'h8000_0000, 32'h0000_b001, 32'hc000_0000);
      idle(2);

      issue(0, 4'b1000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
      repeat (4) @(posedge clk);
      issue(0, 4'b0000, 32'h0000_0005, 32'h0000_0005, 32'hdead_beef);
      repeat (27) @(posedge clk);
      issue(0, 4'b0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
      idle(2);

      issue(0, 4'b1001, 32'h0000_0064, 32'h0000_0007, 32'h0000_000e);
      idle(34);
      issue(0, 4'b1010, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);
      idle(34);
      issue(0, 4'b1001, 32'h0000_0005, 32'h0000_0000, 32'hffff_ffff);
      issue(0, 4'b1010, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
      issue(0, 4'b1011, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000);
      idle(2);

      issue(0, 4'b1000, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0001);
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(40);

      issue(1, 4'b0110, 32'h0000_0080, 32'h0000_000f, 32'h0000_00ff);
      issue(1, 4'b1000, 32'h0000_00ff, 32'h0000_00ff, 32'h0000_0001);
      idle(10);
      issue(1, 4'b1001, 32'h0000_00ff, 32'h0000_0010, 32'h0000_000f);
      idle(10);
      issue(1, 4'b0111, 32'h0000_0080, 32'h0000_0009, 32'h0000_0040);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
